// File: rtl/axi_lite_rr_mux.sv
// axi_lite_rr_mux: NumSlv:1 AXI-Lite mux with independent round-robin write/read arbiters, one transaction in flight per direction.
// Defining AXI_LITE_MUX_PERF_EN adds wr_cnt_o/rd_cnt_o master response handshake counters.
module axi_lite_rr_mux #(
  parameter int NumSlv = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  localparam int StrbWidth = DataWidth / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumSlv-1:0]             slv_aw_valid_i,
  output logic [NumSlv-1:0]             slv_aw_ready_o,
  input  logic [NumSlv*AddrWidth-1:0]   slv_aw_addr_i,
  input  logic [NumSlv*3-1:0]           slv_aw_prot_i,
  input  logic [NumSlv-1:0]             slv_w_valid_i,
  output logic [NumSlv-1:0]             slv_w_ready_o,
  input  logic [NumSlv*DataWidth-1:0]   slv_w_data_i,
  input  logic [NumSlv*StrbWidth-1:0]   slv_w_strb_i,
  output logic [NumSlv-1:0]             slv_b_valid_o,
  input  logic [NumSlv-1:0]             slv_b_ready_i,
  output logic [NumSlv*2-1:0]           slv_b_resp_o,
  input  logic [NumSlv-1:0]             slv_ar_valid_i,
  output logic [NumSlv-1:0]             slv_ar_ready_o,
  input  logic [NumSlv*AddrWidth-1:0]   slv_ar_addr_i,
  input  logic [NumSlv*3-1:0]           slv_ar_prot_i,
  output logic [NumSlv-1:0]             slv_r_valid_o,
  input  logic [NumSlv-1:0]             slv_r_ready_i,
  output logic [NumSlv*DataWidth-1:0]   slv_r_data_o,
  output logic [NumSlv*2-1:0]           slv_r_resp_o,
  output logic                          mst_aw_valid_o,
  input  logic                          mst_aw_ready_i,
  output logic [AddrWidth-1:0]          mst_aw_addr_o,
  output logic [2:0]                    mst_aw_prot_o,
  output logic                          mst_w_valid_o,
  input  logic                          mst_w_ready_i,
  output logic [DataWidth-1:0]          mst_w_data_o,
  output logic [StrbWidth-1:0]          mst_w_strb_o,
  input  logic                          mst_b_valid_i,
  output logic                          mst_b_ready_o,
  input  logic [1:0]                    mst_b_resp_i,
  output logic                          mst_ar_valid_o,
  input  logic                          mst_ar_ready_i,
  output logic [AddrWidth-1:0]          mst_ar_addr_o,
  output logic [2:0]                    mst_ar_prot_o,
  input  logic                          mst_r_valid_i,
  output logic                          mst_r_ready_o,
  input  logic [DataWidth-1:0]          mst_r_data_i,
  input  logic [1:0]                    mst_r_resp_i
`ifdef AXI_LITE_MUX_PERF_EN
  ,
  output logic [31:0]                   wr_cnt_o,
  output logic [31:0]                   rd_cnt_o
`endif
);
  localparam int IdxW = $clog2(NumSlv);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [IdxW-1:0] g_w_q, g_w_d, ptr_w_q, ptr_w_d;
  logic [IdxW-1:0] g_r_q, g_r_d, ptr_r_q, ptr_r_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, aw_hs, w_hs;

  // first requester at or after ptr, wrapping around
  function automatic logic [IdxW-1:0] rr_pick(input logic [NumSlv-1:0] req, input logic [IdxW-1:0] ptr);
    logic [IdxW-1:0] g;
    logic hit;
    int k;
    g = ptr;
    hit = 1'b0;
    for (int i = 0; i < NumSlv; i++) begin
      k = (int'(ptr) + i) % NumSlv;
      if (!hit && req[k]) begin
        g = IdxW'(k);
        hit = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] g);
    return (g == IdxW'(NumSlv - 1)) ? '0 : g + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      g_w_q     <= '0;
      ptr_w_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      r_state_q <= R_IDLE;
      g_r_q     <= '0;
      ptr_r_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      g_w_q     <= g_w_d;
      ptr_w_q   <= ptr_w_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      r_state_q <= r_state_d;
      g_r_q     <= g_r_d;
      ptr_r_q   <= ptr_r_d;
    end
  end

  always_comb begin
    w_state_d      = w_state_q;
    g_w_d          = g_w_q;
    ptr_w_d        = ptr_w_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    aw_hs          = 1'b0;
    w_hs           = 1'b0;
    mst_aw_valid_o = 1'b0;
    mst_w_valid_o  = 1'b0;
    mst_b_ready_o  = 1'b0;
    slv_aw_ready_o = '0;
    slv_w_ready_o  = '0;
    slv_b_valid_o  = '0;
    case (w_state_q)
      W_IDLE: if (|slv_aw_valid_i) begin
        g_w_d     = rr_pick(slv_aw_valid_i, ptr_w_q);
        ptr_w_d   = rr_next(g_w_d);
        w_state_d = W_ADDR;
      end
      W_ADDR: begin
        mst_aw_valid_o        = slv_aw_valid_i[g_w_q] & ~aw_done_q;
        mst_w_valid_o         = slv_w_valid_i[g_w_q] & ~w_done_q;
        slv_aw_ready_o[g_w_q] = mst_aw_ready_i & ~aw_done_q;
        slv_w_ready_o[g_w_q]  = mst_w_ready_i & ~w_done_q;
        aw_hs                 = slv_aw_valid_i[g_w_q] & mst_aw_ready_i & ~aw_done_q;
        w_hs                  = slv_w_valid_i[g_w_q] & mst_w_ready_i & ~w_done_q;
        aw_done_d             = aw_done_q | aw_hs;
        w_done_d              = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_RESP: begin
        slv_b_valid_o[g_w_q] = mst_b_valid_i;
        mst_b_ready_o        = slv_b_ready_i[g_w_q];
        if (mst_b_valid_i && slv_b_ready_i[g_w_q]) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d      = r_state_q;
    g_r_d          = g_r_q;
    ptr_r_d        = ptr_r_q;
    mst_ar_valid_o = 1'b0;
    mst_r_ready_o  = 1'b0;
    slv_ar_ready_o = '0;
    slv_r_valid_o  = '0;
    case (r_state_q)
      R_IDLE: if (|slv_ar_valid_i) begin
        g_r_d     = rr_pick(slv_ar_valid_i, ptr_r_q);
        ptr_r_d   = rr_next(g_r_d);
        r_state_d = R_ADDR;
      end
      R_ADDR: begin
        mst_ar_valid_o        = slv_ar_valid_i[g_r_q];
        slv_ar_ready_o[g_r_q] = mst_ar_ready_i;
        if (slv_ar_valid_i[g_r_q] && mst_ar_ready_i) r_state_d = R_RESP;
      end
      R_RESP: begin
        slv_r_valid_o[g_r_q] = mst_r_valid_i;
        mst_r_ready_o        = slv_r_ready_i[g_r_q];
        if (mst_r_valid_i && slv_r_ready_i[g_r_q]) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign mst_aw_addr_o = slv_aw_addr_i[g_w_q*AddrWidth +: AddrWidth];
  assign mst_aw_prot_o = slv_aw_prot_i[g_w_q*3 +: 3];
  assign mst_w_data_o  = slv_w_data_i[g_w_q*DataWidth +: DataWidth];
  assign mst_w_strb_o  = slv_w_strb_i[g_w_q*StrbWidth +: StrbWidth];
  assign mst_ar_addr_o = slv_ar_addr_i[g_r_q*AddrWidth +: AddrWidth];
  assign mst_ar_prot_o = slv_ar_prot_i[g_r_q*3 +: 3];
  assign slv_b_resp_o  = {NumSlv{mst_b_resp_i}};
  assign slv_r_data_o  = {NumSlv{mst_r_data_i}};
  assign slv_r_resp_o  = {NumSlv{mst_r_resp_i}};

`ifdef AXI_LITE_MUX_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_cnt_o <= '0;
      rd_cnt_o <= '0;
    end else begin
      if (mst_b_valid_i && mst_b_ready_o) wr_cnt_o <= wr_cnt_o + 32'd1;
      if (mst_r_valid_i && mst_r_ready_o) rd_cnt_o <= rd_cnt_o + 32'd1;
    end
  end
`endif
endmodule
